audio_dsp_core: RTL and testbench
=================================

// Module: audio_dsp_core
// PURPOSE
//  Stereo audio DSP stage between audio register interface and serial output.
//  Per tick: stereo 24-bit sample pair -> FIR filter (coeffs from dsp_regs_in) -> per-channel gain -> saturate.
//  Results go out with a one-cycle valid_out strobe.
//  One shared MAC per channel, sequential over taps.
// PARAMETERS
//  FILTER_TAPS    8               taps per channel (>=2)
//  DSP_REGISTERS  2*FILTER_TAPS   32-bit coefficient words in dsp_regs_in
// PORTS
//  clk           in   1     system clock, rising edge
//  rst_n         in   1     reset, asynchronous, active-low
//  tick_in       in   1     1-cycle strobe: new sample pair on audio0_in/audio1_in
//  cfg_in        in   1     1-cycle strobe: latch cfg_reg_in
//  level_in      in   1     1-cycle strobe: latch level_reg_in
//  clr_in        in   1     1-cycle strobe: clear delay lines, abort processing
//  audio0_in     in   24    left sample, signed two's complement
//  audio1_in     in   24    right sample, signed
//  dsp_regs_in   in   DSP_REGISTERS*32  coeffs, signed Q1.31; left tap k [32k+:32], right tap k [32(FILTER_TAPS+k)+:32]
//  level_reg_in  in   32    [15:0] left gain, [31:16] right gain, unsigned Q1.15 (0x8000=1.0)
//  cfg_reg_in    in   32    bit0 FILTER_EN (1=FIR, 0=bypass); bit1 MONO; others ignored
//  dsp0_out      out  24    left result, registered
//  dsp1_out      out  24    right result, registered
//  valid_out     out  1     1-cycle strobe: dsp0_out/dsp1_out updated
// BEHAVIOUR
//  - Reset: dsp0_out=dsp1_out=0, valid_out=0, delay lines=0, cfg=0 (bypass, stereo), gains=0x8000/0x8000, FSM IDLE.
//  - cfg_in/level_in: copy register into internal shadow at clock edge, any state.
//  - Shadows snapshot at tick acceptance; changes while BUSY apply from next tick.
//  - FSM IDLE -> tick_in -> BUSY.
//    - Tick cycle N: shift sample into delay line (tap0 = newest, tap k = k ticks old).
//    - Cycles N+1..N+FILTER_TAPS: one tap MAC per channel per cycle.
//    - N+FILTER_TAPS+1: gain stage.
//    - N+FILTER_TAPS+2: outputs registered, valid_out=1 for exactly that cycle; FSM -> IDLE.
//  - Bypass (FILTER_EN=0) uses identical latency; filtered value = tap0 sample.
//  - tick_in while BUSY: ignored (sample dropped, delay line untouched).
//  - dsp_regs_in read during BUSY; stable from tick to valid_out.
//  - FIR: acc = sum(sample_k * coeff_k), sign-extended 56+clog2(FILTER_TAPS) bits.
//    - y = acc >>> 31 (truncate toward -inf), saturate to [-0x800000, 0x7FFFFF].
//  - Gain: z = (y * gain) >>> 15, gain unsigned 16-bit; saturate to 24-bit signed.
//  - clr_in: highest priority, same cycle.
//    - Delay lines <= 0, FSM -> IDLE, no valid_out for the aborted sample.
//    - dsp0_out/dsp1_out <= 0; shadows unchanged.
//  - clr_in and tick_in together: clear wins, tick ignored.
//  - Reset mid-operation: immediate return to reset state.
// CONFIGURATION
//  - DSP_MONO_EN defined:
//    - cfg bit1 MONO=1: both channels' delay-line input = (audio0_in+audio1_in)>>>1 (25-bit sum, arithmetic shift).
//    - Left coeffs/gain still drive dsp0, right coeffs/gain drive dsp1.
//  - DSP_MONO_EN undefined: bit1 ignored, channels always independent.
// TESTING
//  - Reset held 3 cycles -> dsp0_out=dsp1_out=0, valid_out=0; no valid_out without tick_in.
//  - Bypass, gains 0x8000; tick with audio0=0x100000, audio1=0xF00000
//    -> valid_out exactly FILTER_TAPS+2 cycles later; dsp0=0x100000, dsp1=0xF00000.
//  - FILTER_EN=1, left coeff tap2=0x40000000, all other coeffs 0; impulse 0x400000 then zeros on successive ticks
//    -> dsp0 = 0,0,0x200000,0 on valid strobes 1..4.
//  - Gains 0xFFFF, bypass, audio0=0x7FFFFF, audio1=0x800000 -> dsp0=0x7FFFFF, dsp1=0x800000 (saturated).
//  - tick, then clr_in 3 cycles later -> no valid_out, outputs 0; next impulse response starts from zeroed history.
//  - DSP_MONO_EN, MONO=1, bypass, audio0=0x200000, audio1=0x000000 -> dsp0=dsp1=0x100000.

Source files
------------

// File: rtl/audio_dsp_core.sv
// Stereo FIR -> per-channel gain -> saturate; one MAC per channel stepping over taps. `DSP_MONO_EN adds cfg bit1 mono downmix.
// valid_out pulses FILTER_TAPS+2 cycles after an accepted tick; ticks arriving while busy are dropped, clr_in aborts.
module audio_dsp_core #(
    parameter int FILTER_TAPS   = 8,
    parameter int DSP_REGISTERS = 2*FILTER_TAPS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick_in,
    input  logic                        cfg_in,
    input  logic                        level_in,
    input  logic                        clr_in,
    input  logic signed [23:0]          audio0_in,
    input  logic signed [23:0]          audio1_in,
    input  logic [DSP_REGISTERS*32-1:0] dsp_regs_in,
    input  logic [31:0]                 level_reg_in,
    input  logic [31:0]                 cfg_reg_in,
    output logic signed [23:0]          dsp0_out,
    output logic signed [23:0]          dsp1_out,
    output logic                        valid_out
);

    localparam int ACC_W = 56 + $clog2(FILTER_TAPS);
    localparam int IDX_W = $clog2(FILTER_TAPS);
    localparam int CNT_W = $clog2(FILTER_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILTER_TAPS);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic signed [23:0]      dl0_q [FILTER_TAPS];
    logic signed [23:0]      dl0_d [FILTER_TAPS];
    logic signed [23:0]      dl1_q [FILTER_TAPS];
    logic signed [23:0]      dl1_d [FILTER_TAPS];
    logic [1:0]              cfg_q, cfg_d;
    logic [15:0]             gain0_q, gain0_d, gain1_q, gain1_d;
    logic                    run_fir_q, run_fir_d;
    logic [15:0]             run_g0_q, run_g0_d, run_g1_q, run_g1_d;
    logic signed [23:0]      dsp0_q, dsp0_d, dsp1_q, dsp1_d;
    logic                    valid_q, valid_d;

    logic signed [31:0]      coef0_w [FILTER_TAPS];
    logic signed [31:0]      coef1_w [FILTER_TAPS];
    logic [IDX_W-1:0]        idx;
    logic signed [55:0]      prod0, prod1;
    logic signed [23:0]      in0, in1;
    logic signed [23:0]      fir0, fir1;
    logic signed [16:0]      g0s, g1s;
    logic signed [40:0]      gp0, gp1;

    for (genvar k = 0; k < FILTER_TAPS; k++) begin : g_coef
        assign coef0_w[k] = dsp_regs_in[32*k +: 32];
        assign coef1_w[k] = dsp_regs_in[32*(FILTER_TAPS+k) +: 32];
    end

`ifdef DSP_MONO_EN
    logic signed [24:0] mono_sum;
    logic               unused_cfg;
    assign mono_sum   = {audio0_in[23], audio0_in} + {audio1_in[23], audio1_in};
    assign in0        = cfg_q[1] ? mono_sum[24:1] : audio0_in;
    assign in1        = cfg_q[1] ? mono_sum[24:1] : audio1_in;
    assign unused_cfg = ^cfg_reg_in[31:2];
`else
    logic unused_cfg;
    assign in0        = audio0_in;
    assign in1        = audio1_in;
    assign unused_cfg = ^{cfg_q[1], cfg_reg_in[31:2]};
`endif

    // Keep acc>>>31 (floor) and clamp when the bits above the 24-bit result disagree with its sign.
    function automatic logic signed [23:0] sat_fir(input logic signed [ACC_W-1:0] a);
        if (&a[ACC_W-1:54] || ~|a[ACC_W-1:54]) return a[54:31];
        else if (a[ACC_W-1])                   return 24'sh800000;
        else                                   return 24'sh7FFFFF;
    endfunction

    function automatic logic signed [23:0] sat_gain(input logic signed [40:0] p);
        if (&p[40:38] || ~|p[40:38]) return p[38:15];
        else if (p[40])              return 24'sh800000;
        else                         return 24'sh7FFFFF;
    endfunction

    assign idx   = cnt_q[IDX_W-1:0];
    assign prod0 = dl0_q[idx] * coef0_w[idx];
    assign prod1 = dl1_q[idx] * coef1_w[idx];
    assign fir0  = run_fir_q ? sat_fir(acc0_q) : dl0_q[0];
    assign fir1  = run_fir_q ? sat_fir(acc1_q) : dl1_q[0];
    assign g0s   = {1'b0, run_g0_q};
    assign g1s   = {1'b0, run_g1_q};
    assign gp0   = fir0 * g0s;
    assign gp1   = fir1 * g1s;

    always_comb begin
        cfg_d   = cfg_in   ? cfg_reg_in[1:0]     : cfg_q;
        gain0_d = level_in ? level_reg_in[15:0]  : gain0_q;
        gain1_d = level_in ? level_reg_in[31:16] : gain1_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc0_d    = acc0_q;
        acc1_d    = acc1_q;
        dl0_d     = dl0_q;
        dl1_d     = dl1_q;
        run_fir_d = run_fir_q;
        run_g0_d  = run_g0_q;
        run_g1_d  = run_g1_q;
        dsp0_d    = dsp0_q;
        dsp1_d    = dsp1_q;
        valid_d   = 1'b0;
        if (clr_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc0_d  = '0;
            acc1_d  = '0;
            dsp0_d  = '0;
            dsp1_d  = '0;
            for (int k = 0; k < FILTER_TAPS; k++) begin
                dl0_d[k] = '0;
                dl1_d[k] = '0;
            end
        end else if (state_q == S_IDLE) begin
            if (tick_in) begin
                dl0_d[0] = in0;
                dl1_d[0] = in1;
                for (int k = 1; k < FILTER_TAPS; k++) begin
                    dl0_d[k] = dl0_q[k-1];
                    dl1_d[k] = dl1_q[k-1];
                end
                run_fir_d = cfg_q[0];
                run_g0_d  = gain0_q;
                run_g1_d  = gain1_q;
                cnt_d     = '0;
                acc0_d    = '0;
                acc1_d    = '0;
                state_d   = S_BUSY;
            end
        end else if (cnt_q != LAST_CNT) begin
            acc0_d = acc0_q + {{(ACC_W-56){prod0[55]}}, prod0};
            acc1_d = acc1_q + {{(ACC_W-56){prod1[55]}}, prod1};
            cnt_d  = cnt_q + CNT_W'(1);
        end else begin
            dsp0_d  = sat_gain(gp0);
            dsp1_d  = sat_gain(gp1);
            valid_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            for (int k = 0; k < FILTER_TAPS; k++) begin
                dl0_q[k] <= '0;
                dl1_q[k] <= '0;
            end
            cfg_q     <= '0;
            gain0_q   <= 16'h8000;
            gain1_q   <= 16'h8000;
            run_fir_q <= 1'b0;
            run_g0_q  <= 16'h8000;
            run_g1_q  <= 16'h8000;
            dsp0_q    <= '0;
            dsp1_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc0_q    <= acc0_d;
            acc1_q    <= acc1_d;
            dl0_q     <= dl0_d;
            dl1_q     <= dl1_d;
            cfg_q     <= cfg_d;
            gain0_q   <= gain0_d;
            gain1_q   <= gain1_d;
            run_fir_q <= run_fir_d;
            run_g0_q  <= run_g0_d;
            run_g1_q  <= run_g1_d;
            dsp0_q    <= dsp0_d;
            dsp1_q    <= dsp1_d;
            valid_q   <= valid_d;
        end
    end

    assign dsp0_out  = dsp0_q;
    assign dsp1_out  = dsp1_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_audio_dsp_core.sv
// Bench for audio_dsp_core: timestamped arithmetic model checked every cycle plus hand-computed directed vectors.
// Honours `DSP_MONO_EN for the mono vector.
module tb_audio_dsp_core;
    localparam int T = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick_in, cfg_in, level_in, clr_in;
    logic [23:0]       audio0_in, audio1_in;
    logic [2*T*32-1:0] dsp_regs_in;
    logic [31:0]       level_reg_in, cfg_reg_in;
    logic [23:0]       dsp0_out, dsp1_out;
    logic              valid_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    audio_dsp_core #(.FILTER_TAPS(T)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .cfg_in(cfg_in), .level_in(level_in),
        .clr_in(clr_in), .audio0_in(audio0_in), .audio1_in(audio1_in), .dsp_regs_in(dsp_regs_in),
        .level_reg_in(level_reg_in), .cfg_reg_in(cfg_reg_in), .dsp0_out(dsp0_out),
        .dsp1_out(dsp1_out), .valid_out(valid_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       hist [2][T];
    logic [1:0] m_cfg;
    int       m_g0, m_g1, m_e0, m_e1, m_d0, m_d1, cyc, m_due;
    bit       m_vld, m_busy;

    function automatic int sat24(input longint v);
        if (v > 64'sd8388607)  return 8388607;
        if (v < -64'sd8388608) return -8388608;
        return int'(v);
    endfunction

    function automatic int coef(input int ch, input int k);
        logic [31:0] w;
        w = dsp_regs_in[32*(ch*T+k) +: 32];
        return $signed(w);
    endfunction

    function automatic int chan_out(input int ch, input bit fir, input int gain);
        longint acc, y;
        acc = 0;
        if (fir) begin
            for (int k = 0; k < T; k++) acc += longint'(hist[ch][k]) * longint'(coef(ch, k));
            y = sat24(acc >>> 31);
        end else begin
            y = hist[ch][0];
        end
        return sat24((y * gain) >>> 15);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) for (int k = 0; k < T; k++) hist[c][k] = 0;
            m_cfg = 2'b00; m_g0 = 32768; m_g1 = 32768;
            m_d0 = 0; m_d1 = 0; m_vld = 0; m_busy = 0; cyc = 0; m_due = 0;
        end else begin
            int a0, a1;
            cyc++;
            m_vld = 0;
            if (clr_in) begin
                for (int c = 0; c < 2; c++) for (int k = 0; k < T; k++) hist[c][k] = 0;
                m_busy = 0; m_d0 = 0; m_d1 = 0;
            end else if (m_busy) begin
                if (cyc == m_due) begin
                    m_d0 = m_e0; m_d1 = m_e1; m_vld = 1; m_busy = 0;
                end
            end else if (tick_in) begin
                a0 = $signed(audio0_in);
                a1 = $signed(audio1_in);
`ifdef DSP_MONO_EN
                if (m_cfg[1]) begin
                    a0 = (a0 + a1) >>> 1;
                    a1 = a0;
                end
`endif
                for (int k = T-1; k > 0; k--) begin
                    hist[0][k] = hist[0][k-1];
                    hist[1][k] = hist[1][k-1];
                end
                hist[0][0] = a0;
                hist[1][0] = a1;
                m_e0 = chan_out(0, m_cfg[0], m_g0);
                m_e1 = chan_out(1, m_cfg[0], m_g1);
                m_due = cyc + T + 1;
                m_busy = 1;
            end
            if (cfg_in) m_cfg = cfg_reg_in[1:0];
            if (level_in) begin
                m_g0 = level_reg_in[15:0];
                m_g1 = level_reg_in[31:16];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid", {31'b0, valid_out}, {31'b0, m_vld});
            check("cyc_dsp0", dsp0_out, m_d0[23:0]);
            check("cyc_dsp1", dsp1_out, m_d1[23:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [23:0] a0, input logic [23:0] a1);
        audio0_in = a0; audio1_in = a1; tick_in = 1'b1;
        idle(1);
        tick_in = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] v);
        cfg_reg_in = v; cfg_in = 1'b1;
        idle(1);
        cfg_in = 1'b0;
    endtask

    task automatic set_level(input logic [31:0] v);
        level_reg_in = v; level_in = 1'b1;
        idle(1);
        level_in = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_in = 1'b1;
        idle(1);
        clr_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic tick_wait(input logic [23:0] a0, input logic [23:0] a1);
        int lat;
        tick(a0, a1);
        wait_valid(lat);
        check("latency", lat, T + 2);
    endtask

    task automatic count_valid(input int n, output int cnt, output logic [23:0] last0);
        cnt = 0; last0 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_out) begin
                cnt++;
                last0 = dsp0_out;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lat;
        logic [23:0] last0;
        rst_n = 1'b0; tick_in = 1'b0; cfg_in = 1'b0; level_in = 1'b0; clr_in = 1'b0;
        audio0_in = '0; audio1_in = '0; dsp_regs_in = '0;
        level_reg_in = 32'h8000_8000; cfg_reg_in = '0;

        // reset state
        idle(3);
        check("rst_dsp0", dsp0_out, 24'h0);
        check("rst_dsp1", dsp1_out, 24'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        count_valid(6, cnt, last0);
        check("idle_no_valid", cnt, 0);

        // bypass, unity gain
        tick_wait(24'h100000, 24'hF00000);
        check("bypass_l", dsp0_out, 24'h100000);
        check("bypass_r", dsp1_out, 24'hF00000);

        // impulse through left tap2 = 0.5
        pulse_clr();
        check("clr_out", dsp0_out, 24'h0);
        dsp_regs_in = '0;
        dsp_regs_in[32*2 +: 32] = 32'h4000_0000;
        set_cfg(32'h1);
        tick_wait(24'h400000, 24'h0); check("imp1", dsp0_out, 24'h000000);
        tick_wait(24'h000000, 24'h0); check("imp2", dsp0_out, 24'h000000);
        tick_wait(24'h000000, 24'h0); check("imp3", dsp0_out, 24'h200000);
        tick_wait(24'h000000, 24'h0); check("imp4", dsp0_out, 24'h000000);

        // floor rounding and right-channel coefficient mapping
        dsp_regs_in = '0;
        dsp_regs_in[0 +: 32]    = 32'h4000_0000;
        dsp_regs_in[32*T +: 32] = 32'h2000_0000;
        tick_wait(24'hFFFFFF, 24'h000100);
        check("fir_floor", dsp0_out, 24'hFFFFFF);
        check("fir_right", dsp1_out, 24'h000040);

        // FIR accumulate, then accumulator saturation
        dsp_regs_in = '0;
        dsp_regs_in[0 +: 32]  = 32'h7FFF_FFFF;
        dsp_regs_in[32 +: 32] = 32'h7FFF_FFFF;
        tick_wait(24'h7FFFFF, 24'h0); check("fir_sum", dsp0_out, 24'h7FFFFD);
        tick_wait(24'h7FFFFF, 24'h0); check("fir_sat", dsp0_out, 24'h7FFFFF);

        // gain saturation and fractional gain
        set_cfg(32'h0);
        set_level(32'hFFFF_FFFF);
        tick_wait(24'h7FFFFF, 24'h800000);
        check("gain_sat_hi", dsp0_out, 24'h7FFFFF);
        check("gain_sat_lo", dsp1_out, 24'h800000);
        set_level(32'h0000_4000);
        tick_wait(24'hFFFFFD, 24'h123456);
        check("gain_half", dsp0_out, 24'hFFFFFE);
        check("gain_zero", dsp1_out, 24'h000000);

        // clear mid-processing aborts and zeroes history
        set_level(32'h8000_8000);
        set_cfg(32'h1);
        dsp_regs_in = '0;
        dsp_regs_in[32 +: 32] = 32'h4000_0000;
        tick(24'h400000, 24'h0);
        idle(2);
        pulse_clr();
        count_valid(20, cnt, last0);
        check("clr_no_valid", cnt, 0);
        check("clr_dsp0", dsp0_out, 24'h0);
        tick_wait(24'h200000, 24'h0); check("post_clr1", dsp0_out, 24'h000000);
        tick_wait(24'h000000, 24'h0); check("post_clr2", dsp0_out, 24'h100000);

        // tick while busy is dropped
        tick(24'h000200, 24'h0);
        idle(2);
        tick(24'h000400, 24'h0);
        count_valid(20, cnt, last0);
        check("drop_count", cnt, 1);
        check("drop_val", last0, 24'h000000);
        tick_wait(24'h000000, 24'h0); check("drop_hist", dsp0_out, 24'h000100);

        // gain change while busy applies from the next tick
        set_cfg(32'h0);
        tick(24'h000800, 24'h000800);
        set_level(32'h4000_4000);
        wait_valid(lat);
        check("busy_lat", lat, T + 1);
        check("busy_old_gain", dsp0_out, 24'h000800);
        tick_wait(24'h000800, 24'h000800);
        check("new_gain_l", dsp0_out, 24'h000400);
        check("new_gain_r", dsp1_out, 24'h000400);
        set_level(32'h8000_8000);

        // mono downmix (bit1 ignored in the default build)
        set_cfg(32'h2);
        tick_wait(24'h200000, 24'h000000);
`ifdef DSP_MONO_EN
        check("mono_l", dsp0_out, 24'h100000);
        check("mono_r", dsp1_out, 24'h100000);
`else
        check("stereo_l", dsp0_out, 24'h200000);
        check("stereo_r", dsp1_out, 24'h000000);
`endif

        // reset mid-operation
        set_cfg(32'h0);
        set_level(32'h4000_4000);
        tick(24'h000100, 24'h000100);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        check("mid_rst_dsp0", dsp0_out, 24'h0);
        check("mid_rst_dsp1", dsp1_out, 24'h0);
        check("mid_rst_valid", {31'b0, valid_out}, 32'h0);
        rst_n = 1'b1;
        count_valid(20, cnt, last0);
        check("mid_rst_no_valid", cnt, 0);
        tick_wait(24'h000300, 24'hFFFD00);
        check("rst_gain_l", dsp0_out, 24'h000300);
        check("rst_gain_r", dsp1_out, 24'hFFFD00);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
